// File: rtl/rr_mux4_arbiter_if.sv
// Channel between four requesters, the round-robin arbiter and one shared consumer.
// The arbiter side uses modport master; the requesters/consumer side uses modport slave.
interface rr_mux4_arbiter_if #(
  parameter int DATA_W = 8
);
  // Handshakes: gnt[k] is the one-cycle acknowledge for a stable req[k]/i<k>.
  // A word moves to the consumer on every rising edge where out_valid & out_ready.
  // out_data/out_src stay stable while out_valid & !out_ready.
  logic [3:0]        req;
  logic [DATA_W-1:0] i0;
  logic [DATA_W-1:0] i1;
  logic [DATA_W-1:0] i2;
  logic [DATA_W-1:0] i3;
  logic [3:0]        gnt;
  logic [1:0]        selection_line;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;

  modport master (
    input  req, i0, i1, i2, i3, out_ready,
    output gnt, selection_line, out_valid, out_data, out_src
  );

  modport slave (
    output req, i0, i1, i2, i3, out_ready,
    input  gnt, selection_line, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter: picks one of four requesters per accept slot, drives the mux select
// and registers the selected word into a single-entry valid/ready output stage.
module rr_mux4_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_mux4_arbiter_if.master    bus,
  output logic                 state_dbg,
  output logic [1:0]           ptr_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        src_q, src_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              accept;
  logic              found;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic [DATA_W-1:0] win_data;

  // Search starts just after the last winner, so the last winner is tried last.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int off = 1; off <= 4; off++) begin
      idx = ptr_q + 2'(off);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    case (win)
      2'd0:    win_data = bus.i0;
      2'd1:    win_data = bus.i1;
      2'd2:    win_data = bus.i2;
      default: win_data = bus.i3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      src_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    src_d              = src_q;
    data_d             = data_q;
    bus.gnt            = 4'b0000;
    bus.selection_line = src_q;
    accept             = (state_q == IDLE) || bus.out_ready;
    if (!reset && accept) begin
      if (found) begin
        bus.gnt            = 4'b0001 << win;
        bus.selection_line = win;
        data_d             = win_data;
        src_d              = win;
        ptr_d              = win;
        state_d            = FULL;
      end else begin
        // Stage drains (or stays empty) when nobody is asking.
        state_d = IDLE;
      end
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign state_dbg     = state_q;
  assign ptr_dbg       = ptr_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: reset, single grant, rotation, backpressure,
// wrap-around, single requester and reset while holding a word.
module tb_rr_mux4_arbiter;
  localparam int DATA_W = 8;

  logic clk;
  logic reset;
  logic state_dbg;
  logic [1:0] ptr_dbg;

  int chk_cnt = 0;
  int err_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  rr_mux4_arbiter_if #(.DATA_W(DATA_W)) bus ();

  rr_mux4_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg),
    .ptr_dbg   (ptr_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    logic [3:0] g;
    logic [DATA_W-1:0] d;

    reset         = 1'b1;
    bus.req       = 4'hF;
    bus.i0        = 8'h10;
    bus.i1        = 8'h11;
    bus.i2        = 8'h12;
    bus.i3        = 8'h13;
    bus.out_ready = 1'b0;

    // 1. reset held two cycles with all requests up
    for (int c = 0; c < 2; c++) begin
      tick(); settle();
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      check("rst_valid", 32'(bus.out_valid), 32'h0);
      check("rst_data", 32'(bus.out_data), 32'h0);
      check("rst_ptr", 32'(ptr_dbg), 32'h3);
    end
    tick();
    reset = 1'b0;
    settle();
    check("first_gnt", 32'(bus.gnt), 32'h1);
    check("first_sel", 32'(bus.selection_line), 32'h0);
    tick();
    bus.req = 4'h0;
    settle();
    check("first_valid", 32'(bus.out_valid), 32'h1);
    check("first_data", 32'(bus.out_data), 32'h10);
    check("hold_gnt", 32'(bus.gnt), 32'h0);
    bus.out_ready = 1'b1;
    #1;
    check("drain_gnt", 32'(bus.gnt), 32'h0);
    check("drain_sel", 32'(bus.selection_line), 32'h0);
    tick(); settle();
    check("drain_valid", 32'(bus.out_valid), 32'h0);
    check("drain_state", 32'(state_dbg), 32'h0);

    // 2. single request from 2
    bus.req = 4'b0100;
    bus.i2  = 8'hA5;
    #1;
    check("t2_gnt", 32'(bus.gnt), 32'h4);
    check("t2_sel", 32'(bus.selection_line), 32'h2);
    tick();
    bus.req = 4'h0;
    settle();
    check("t2_valid", 32'(bus.out_valid), 32'h1);
    check("t2_data", 32'(bus.out_data), 32'hA5);
    check("t2_src", 32'(bus.out_src), 32'h2);

    // 3. grant 3 first so rotation starts at 0, then all requests held
    bus.req = 4'b1000;
    #1;
    check("t3_pre_gnt", 32'(bus.gnt), 32'h8);
    tick();
    bus.req = 4'hF;
    bus.i0  = 8'h10;
    bus.i1  = 8'h11;
    bus.i2  = 8'h12;
    bus.i3  = 8'h13;
    settle();
    check("t3_pre_data", 32'(bus.out_data), 32'h13);
    for (int n = 0; n < 6; n++) begin
      g = 4'(1 << (n % 4));
      d = 8'h10 + 8'(n % 4);
      check("t3_gnt", 32'(bus.gnt), 32'(g));
      exp_q.push_back(d);
      tick(); settle();
      check("t3_valid", 32'(bus.out_valid), 32'h1);
      check("t3_src", 32'(bus.out_src), 32'(n % 4));
      check("t3_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end

    // 4. backpressure for 5 cycles holding 8'h11
    bus.out_ready = 1'b0;
    bus.req       = 4'b1000;
    bus.i3        = 8'h33;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("t4_gnt", 32'(bus.gnt), 32'h0);
      check("t4_data", 32'(bus.out_data), 32'h11);
      check("t4_valid", 32'(bus.out_valid), 32'h1);
      tick(); settle();
    end
    check("t4_ptr", 32'(ptr_dbg), 32'h1);
    bus.out_ready = 1'b1;
    #1;
    check("t4_rel_gnt", 32'(bus.gnt), 32'h8);
    check("t4_rel_sel", 32'(bus.selection_line), 32'h3);
    tick(); settle();
    check("t4_rel_data", 32'(bus.out_data), 32'h33);
    check("t4_rel_src", 32'(bus.out_src), 32'h3);

    // 5. wrap: ptr=3 with req 0 and 3 -> 0 first, then 3; then only 3 repeatedly
    bus.req = 4'b1001;
    bus.i0  = 8'h40;
    bus.i3  = 8'h43;
    #1;
    check("t5_gnt0", 32'(bus.gnt), 32'h1);
    tick(); settle();
    check("t5_data0", 32'(bus.out_data), 32'h40);
    check("t5_gnt3", 32'(bus.gnt), 32'h8);
    tick();
    bus.req = 4'b1000;
    settle();
    check("t5_data3", 32'(bus.out_data), 32'h43);
    for (int c = 0; c < 3; c++) begin
      check("t5_solo_gnt", 32'(bus.gnt), 32'h8);
      tick(); settle();
      check("t5_solo_src", 32'(bus.out_src), 32'h3);
    end

    // 6. reset while holding 8'h5A
    bus.i3 = 8'h5A;
    #1;
    check("t6_gnt", 32'(bus.gnt), 32'h8);
    tick(); settle();
    check("t6_data", 32'(bus.out_data), 32'h5A);
    bus.out_ready = 1'b0;
    bus.req       = 4'h0;
    reset         = 1'b1;
    #1;
    check("t6_rst_gnt", 32'(bus.gnt), 32'h0);
    tick();
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    settle();
    check("t6_valid", 32'(bus.out_valid), 32'h0);
    check("t6_data_clr", 32'(bus.out_data), 32'h0);
    check("t6_ptr", 32'(ptr_dbg), 32'h3);
    tick(); settle();
    check("t6_still_empty", 32'(bus.out_valid), 32'h0);
    bus.req = 4'hF;
    #1;
    check("t6_regrant", 32'(bus.gnt), 32'h1);
    tick(); settle();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
